// File: rtl/act_pkg.sv
// Shared types and helpers for the sparse activation gather unit.
package act_pkg;

    typedef enum logic {IDLE, SCAN} gather_state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/act_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next pending activation.
module act_prio_enc #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan downward so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/act_sparse_gather_unit.sv
// Streams the mask-selected (and optionally nonzero) activations of a block,
// one per cycle in ascending index order, with zero-bubble block chaining.
module act_sparse_gather_unit
    import act_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 8,
    parameter  int unsigned BLOCK_NUMBER = 16,
    localparam int unsigned IDX_WIDTH    = $clog2(BLOCK_NUMBER)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               In_valid,
    output logic                               In_ready,
    input  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] Input_act_data,
    input  logic [BLOCK_NUMBER-1:0]            Weight_mask,
    input  logic                               Skip_zero_act,
    output logic                               Out_valid,
    input  logic                               Out_ready,
    output logic [DATA_WIDTH-1:0]              Output_act_data,
    output logic [IDX_WIDTH-1:0]               Output_idx,
    output logic                               Output_last,
    output logic                               Empty_block
);

    localparam int unsigned BUS_W = BLOCK_NUMBER * DATA_WIDTH;

    gather_state_t             state_q, state_d;
    logic [BUS_W-1:0]          data_q, data_d;
    logic [BLOCK_NUMBER-1:0]   pend_q, pend_d;
    logic                      empty_q, empty_d;

    logic [BLOCK_NUMBER-1:0]   nz;
    logic [BLOCK_NUMBER-1:0]   eff;
    logic [IDX_WIDTH-1:0]      head_idx;
    logic                      pend_any;
    logic                      scan;
    logic                      accept;
    logic                      out_hs;

    // Effective selection for the block on the input port.
    always_comb begin
        nz = '0;
        for (int i = 0; i < int'(BLOCK_NUMBER); i++) begin
            nz[i] = |Input_act_data[DATA_WIDTH*i +: DATA_WIDTH];
        end
        eff = Weight_mask & (Skip_zero_act ? nz : '1);
    end

    act_prio_enc #(.WIDTH(BLOCK_NUMBER)) u_prio_enc (
        .vec (pend_q),
        .idx (head_idx),
        .any (pend_any)
    );

    // Outputs derive only from registers, except In_ready's path from Out_ready.
    assign scan            = (state_q == SCAN) && pend_any;
    assign Out_valid       = scan;
    assign Output_idx      = head_idx;
    assign Output_last     = scan && is_onehot(64'(pend_q));
    assign Output_act_data = scan ? data_q[DATA_WIDTH*head_idx +: DATA_WIDTH] : '0;
    assign Empty_block     = empty_q;
    assign In_ready        = (state_q == IDLE) || (Output_last && Out_ready);

    assign accept = In_valid && In_ready;
    assign out_hs = scan && Out_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        data_d  = data_q;
        empty_d = 1'b0;
        if (out_hs) begin
            pend_d = pend_q & (pend_q - BLOCK_NUMBER'(1));
            if (Output_last) state_d = IDLE;
        end
        // A new block overrides the drained pending set on the final beat.
        if (accept) begin
            data_d  = Input_act_data;
            pend_d  = eff;
            empty_d = (eff == '0);
            state_d = (eff == '0) ? IDLE : SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            pend_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: tb/tb_act_sparse_gather_unit.sv
// Scoreboard bench for act_sparse_gather_unit: directed and random blocks
// checked against a per-block selection model.
module tb_act_sparse_gather_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         In_valid;
    logic         In_ready;
    logic [127:0] Input_act_data;
    logic [15:0]  Weight_mask;
    logic         Skip_zero_act;
    logic         Out_valid;
    logic         Out_ready;
    logic [7:0]   Output_act_data;
    logic [3:0]   Output_idx;
    logic         Output_last;
    logic         Empty_block;

    act_sparse_gather_unit #(.DATA_WIDTH(8), .BLOCK_NUMBER(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .In_valid        (In_valid),
        .In_ready        (In_ready),
        .Input_act_data  (Input_act_data),
        .Weight_mask     (Weight_mask),
        .Skip_zero_act   (Skip_zero_act),
        .Out_valid       (Out_valid),
        .Out_ready       (Out_ready),
        .Output_act_data (Output_act_data),
        .Output_idx      (Output_idx),
        .Output_last     (Output_last),
        .Empty_block     (Empty_block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] idx;
        logic       last;
        logic       empty;
    } exp_t;

    typedef struct {
        int   c;
        logic ne;
    } lat_t;

    exp_t q[$];
    lat_t lat_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready pattern: 0 always ready, 1 toggle, 2 random.
    always @(posedge clk) begin
        #1;
        case (mode)
            1:       Out_ready = ~Out_ready;
            2:       Out_ready = ($urandom % 4) != 0;
            default: Out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] a[16]);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = a[i];
        return v;
    endfunction

    // Reference: selected positions in ascending order, or a lone empty marker.
    function automatic logic model(input logic [15:0] mask, input logic [7:0] a[16], input logic skip);
        exp_t sel[$];
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (mask[i] && (!skip || a[i] != 8'd0)) begin
                e.data = a[i]; e.idx = 4'(i); e.last = 1'b0; e.empty = 1'b0;
                sel.push_back(e);
            end
        end
        if (sel.size() == 0) begin
            e.data = 8'd0; e.idx = 4'd0; e.last = 1'b0; e.empty = 1'b1;
            q.push_back(e);
            return 1'b0;
        end
        sel[sel.size()-1].last = 1'b1;
        foreach (sel[k]) q.push_back(sel[k]);
        return 1'b1;
    endfunction

    task automatic send(input logic [15:0] mask, input logic [7:0] a[16], input logic skip);
        bit   done = 0;
        lat_t l;
        Weight_mask    = mask;
        Skip_zero_act  = skip;
        Input_act_data = pack(a);
        In_valid       = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (In_ready) begin
                l.ne = model(mask, a, skip);
                l.c  = cyc + 1;
                lat_q.push_back(l);
                done = 1;
            end
            @(posedge clk); #1;
        end
        In_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake or empty pulse.
    logic       stall_prev = 1'b0;
    logic [7:0] h_data;
    logic [3:0] h_idx;
    logic       h_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (lat_q.size() > 0 && lat_q[0].c == cyc) begin
                check("latency", {30'd0, Out_valid, Empty_block}, lat_q[0].ne ? 32'd2 : 32'd1);
                void'(lat_q.pop_front());
            end
            if (stall_prev)
                check("stall_hold", {19'd0, Out_valid, Output_act_data, Output_idx, Output_last},
                      {19'd0, 1'b1, h_data, h_idx, h_last});
            if (Out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", {19'd0, Output_act_data, Output_idx, Output_last}, 32'd0);
                end else begin
                    check("beat", {19'd0, q[0].empty, Output_act_data, Output_idx, Output_last},
                          {19'd0, 1'b0, q[0].data, q[0].idx, q[0].last});
                    check("in_ready", {31'd0, In_ready}, {31'd0, q[0].last && Out_ready});
                    if (Out_ready) void'(q.pop_front());
                end
            end
            if (Empty_block) begin
                if (q.size() == 0 || !q[0].empty) begin
                    check("unexpected_empty", 32'd1, 32'd0);
                end else begin
                    check("empty", {31'd0, Empty_block}, 32'd1);
                    void'(q.pop_front());
                end
            end
            stall_prev = Out_valid && !Out_ready;
            h_data = Output_act_data; h_idx = Output_idx; h_last = Output_last;
        end
    end

    task automatic drain();
        for (int c = 0; c < 500 && q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);
    endtask

    logic [7:0] a[16];
    logic [15:0] m;

    initial begin
        rst_n = 1'b0; In_valid = 1'b0; Weight_mask = '0; Skip_zero_act = 1'b0;
        Input_act_data = '0; Out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {19'd0, Out_valid, Output_act_data, Output_idx, Output_last, Empty_block}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, In_ready}, 32'd1);
        @(posedge clk); #1;

        // Dense block
        for (int i = 0; i < 16; i++) a[i] = 8'(i + 1);
        send(16'hFFFF, a, 1'b0);
        // Sparse block, chained
        for (int i = 0; i < 16; i++) a[i] = 8'(i + 16);
        send(16'h8421, a, 1'b0);
        // Zero skip on and off
        for (int i = 0; i < 16; i++) a[i] = 8'(i + 1);
        a[2] = 8'd0; a[3] = 8'd0;
        send(16'h00FF, a, 1'b1);
        send(16'h00FF, a, 1'b0);
        drain();

        // Empty block between two live blocks, In_valid held
        for (int i = 0; i < 16; i++) a[i] = 8'(8'hA0 + i);
        send(16'h0003, a, 1'b0);
        send(16'h0000, a, 1'b0);
        send(16'h0010, a, 1'b0);
        drain();

        // Backpressure
        mode = 1;
        send(16'h0101, a, 1'b0);
        drain();
        mode = 0;
        @(posedge clk); #1;

        // Asynchronous reset after two of five beats
        send(16'h1113, a, 1'b0);
        @(posedge clk); @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outs", {19'd0, Out_valid, Output_act_data, Output_idx, Output_last, Empty_block}, 32'd0);
        q.delete(); lat_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", {31'd0, Out_valid}, 32'd0);
        send(16'h00C0, a, 1'b0);
        drain();

        // Random blocks under random backpressure
        mode = 2;
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 16; i++) a[i] = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
            case ($urandom % 8)
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                default: m = 16'($urandom);
            endcase
            send(m, a, 1'($urandom % 2));
            if (($urandom % 3) == 0) repeat ($urandom % 4) @(posedge clk);
            #1;
        end
        mode = 0;
        drain();
        check("latency_drain", 32'(lat_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
